// File: rtl/cfg_bram_master.sv
// Command-driven burst master for a single-port BRAM: write bursts stream
// wr_data into consecutive words, read bursts fetch one word at a time.
module cfg_bram_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_NUM   = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic                  busy,
    output logic                  bram_en,
    output logic [BYTE_NUM-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC  = ADDR_WIDTH'(BYTE_NUM);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);
    localparam logic [LAT_W-1:0]      LAT_LOAD  = LAT_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [LAT_W-1:0]      lat_q, lat_d;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  bram_en_q, bram_en_d;
    logic [BYTE_NUM-1:0]   bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;

    // Every output is computed one cycle ahead so it can leave straight from a flop.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        cmd_ready_d = 1'b0;
        wr_ready_d  = 1'b0;
        done_d      = 1'b0;
        bram_en_d   = 1'b0;
        bram_we_d   = '0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        rd_data_d   = rd_data_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr & ADDR_MASK;
                    cnt_d       = cmd_len;
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        state_d    = WR;
                        wr_ready_d = 1'b1;
                    end else begin
                        state_d     = RD_ISSUE;
                        bram_en_d   = 1'b1;
                        bram_addr_d = cmd_addr & ADDR_MASK;
                    end
                end
            end
            WR: begin
                wr_ready_d = 1'b1;
                if (wr_valid && wr_ready_q) begin
                    bram_en_d   = 1'b1;
                    bram_we_d   = '1;
                    bram_addr_d = addr_q;
                    bram_din_d  = wr_data;
                    addr_d      = addr_q + ADDR_INC;
                    cnt_d       = cnt_q - 8'd1;
                    if (cnt_q == 8'd0) begin
                        state_d     = IDLE;
                        wr_ready_d  = 1'b0;
                        cmd_ready_d = 1'b1;
                        done_d      = 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                lat_d   = LAT_LOAD;
            end
            RD_WAIT: begin
                if (lat_q == '0) begin
                    rd_data_d  = bram_dout;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (cnt_q == 8'd0);
                    state_d    = RD_HOLD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RD_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (cnt_q == 8'd0) begin
                        state_d     = IDLE;
                        cmd_ready_d = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        // Next read is issued immediately, keeping one read in flight.
                        addr_d      = addr_q + ADDR_INC;
                        cnt_d       = cnt_q - 8'd1;
                        state_d     = RD_ISSUE;
                        bram_en_d   = 1'b1;
                        bram_addr_d = addr_q + ADDR_INC;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;

endmodule
